bus_mux_reg: RTL and testbench

//  Parametrised, registered datapath bus. Successor to the combinational encoder+mux bus.
//  N_SRC one-hot source enables plus a C-immediate source drive one WORD-wide bus

---
 rtl/bus_mux_reg_if.sv | 46 ++++
 rtl/bus_mux_reg.sv | 125 ++++++++++++
 tb/tb_bus_mux_reg.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/bus_mux_reg_if.sv
// Bundle of bus_mux_reg data and status signals.
//   master : drives the source enables, source data, C immediate and err_clr;
//            observes the registered bus and the conflict status.
//   slave  : the bus_mux_reg side (inputs and outputs reversed).
// Signals:
//   src_en          N_SRC       per-source drive enable
//   src_data        N_SRC*WORD  flat source data, source i at [i*WORD +: WORD]
//   c_en            1           C-immediate drive enable
//   c_field         C_WIDTH     C immediate, two's complement
//   err_clr         1           synchronous clear of the conflict sticky bit and counter
//   bus_out         WORD        registered bus value
//   bus_valid       1           bus_out was loaded from a driver
//   sel_idx         SelW        index of the winning driver (N_SRC = C)
//   conflict        1           more than one driver in the sampled cycle
//   conflict_sticky 1           a conflict has occurred since the last clear
//   conflict_cnt    CNT_W       saturating conflict-cycle count
interface bus_mux_reg_if #(
   parameter int unsigned WORD    = 32,
   parameter int unsigned N_SRC   = 23,
   parameter int unsigned C_WIDTH = 19,
   parameter int unsigned CNT_W   = 8
);
   localparam int unsigned SelW = $clog2(N_SRC + 1);

   logic [N_SRC-1:0]      src_en;
   logic [N_SRC*WORD-1:0] src_data;
   logic                  c_en;
   logic [C_WIDTH-1:0]    c_field;
   logic                  err_clr;
   logic [WORD-1:0]       bus_out;
   logic                  bus_valid;
   logic [SelW-1:0]       sel_idx;
   logic                  conflict;
   logic                  conflict_sticky;
   logic [CNT_W-1:0]      conflict_cnt;

   modport master (
      output src_en, src_data, c_en, c_field, err_clr,
      input  bus_out, bus_valid, sel_idx, conflict, conflict_sticky, conflict_cnt
   );

   modport slave (
      input  src_en, src_data, c_en, c_field, err_clr,
      output bus_out, bus_valid, sel_idx, conflict, conflict_sticky, conflict_cnt
   );
endinterface

// File: rtl/bus_mux_reg.sv
// Registered datapath bus. N_SRC one-hot register sources plus a sign-extended C immediate
// drive a single WORD-wide output register (1-cycle latency). The lowest-indexed asserted
// driver wins (R0 highest priority, C lowest). Also reports multi-driver conflicts with a
// per-cycle flag, a sticky flag and a saturating counter.
// Ports:
//   clk     rising-edge clock
//   clr     asynchronous active-high reset, clears every output register
//   bus_if  bus_mux_reg_if slave modport (sources, enables, C field, err_clr, outputs)
module bus_mux_reg #(
   parameter int unsigned WORD      = 32,
   parameter int unsigned N_SRC     = 23,
   parameter int unsigned C_WIDTH   = 19,
   parameter bit          HOLD_IDLE = 1'b1,
   parameter int unsigned CNT_W     = 8
) (
   input logic            clk,
   input logic            clr,
   bus_mux_reg_if.slave   bus_if
);
   localparam int unsigned SelW = $clog2(N_SRC + 1);
   localparam logic [CNT_W-1:0] CntMax = '1;

   // Sign-extended C immediate; a full-width field needs no extension.
   logic [WORD-1:0] c_sext;
   if (C_WIDTH < WORD) begin : g_sext
      assign c_sext = {{(WORD - C_WIDTH){bus_if.c_field[C_WIDTH-1]}}, bus_if.c_field};
   end else begin : g_nosext
      assign c_sext = bus_if.c_field;
   end

   // Priority select and conflict detection
   logic            win_found;
   logic            multi_drv;
   logic [SelW-1:0] win_idx;
   logic [WORD-1:0] win_data;

   always_comb begin
      win_found = 1'b0;
      multi_drv = 1'b0;
      win_idx   = '0;
      win_data  = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (bus_if.src_en[i]) begin
            if (win_found) begin
               multi_drv = 1'b1;
            end else begin
               win_found = 1'b1;
               win_idx   = SelW'(i);
               win_data  = bus_if.src_data[i*WORD +: WORD];
            end
         end
      end
      // C is the lowest-priority logical driver, index N_SRC.
      if (bus_if.c_en) begin
         if (win_found) begin
            multi_drv = 1'b1;
         end else begin
            win_found = 1'b1;
            win_idx   = SelW'(N_SRC);
            win_data  = c_sext;
         end
      end
   end

   // Output registers
   logic [WORD-1:0]  bus_q, bus_d;
   logic             valid_q, valid_d;
   logic [SelW-1:0]  sel_q, sel_d;
   logic             conf_q, conf_d;
   logic             sticky_q, sticky_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Clear-then-count staging so a conflict in the err_clr cycle still registers.
   logic             sticky_base;
   logic [CNT_W-1:0] cnt_base;

   always_comb begin
      bus_d   = bus_q;
      valid_d = 1'b0;
      sel_d   = '0;
      conf_d  = multi_drv;

      if (win_found) begin
         bus_d   = win_data;
         valid_d = 1'b1;
         sel_d   = win_idx;
      end else if (!HOLD_IDLE) begin
         bus_d = '0;
      end

      sticky_base = bus_if.err_clr ? 1'b0 : sticky_q;
      cnt_base    = bus_if.err_clr ? '0 : cnt_q;

      sticky_d = sticky_base | multi_drv;
      cnt_d    = cnt_base;
      if (multi_drv && (cnt_base != CntMax)) begin
         cnt_d = cnt_base + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         bus_q    <= '0;
         valid_q  <= 1'b0;
         sel_q    <= '0;
         conf_q   <= 1'b0;
         sticky_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         bus_q    <= bus_d;
         valid_q  <= valid_d;
         sel_q    <= sel_d;
         conf_q   <= conf_d;
         sticky_q <= sticky_d;
         cnt_q    <= cnt_d;
      end
   end

   assign bus_if.bus_out         = bus_q;
   assign bus_if.bus_valid       = valid_q;
   assign bus_if.sel_idx         = sel_q;
   assign bus_if.conflict        = conf_q;
   assign bus_if.conflict_sticky = sticky_q;
   assign bus_if.conflict_cnt    = cnt_q;
endmodule

// File: tb/tb_bus_mux_reg.sv
// Scoreboard bench for bus_mux_reg. Two instances share stimulus: one with bus hold on idle,
// one loading zero on idle. Expected results are computed from a behavioural model when
// stimulus is applied, queued, and popped for comparison one edge later.
module tb_bus_mux_reg;
   localparam int unsigned WORD    = 32;
   localparam int unsigned N_SRC   = 23;
   localparam int unsigned C_WIDTH = 19;
   localparam int unsigned CNT_W   = 8;
   localparam int unsigned SelW    = $clog2(N_SRC + 1);

   typedef struct {
      logic [WORD-1:0]  bus_hold;
      logic [WORD-1:0]  bus_zero;
      logic             valid;
      logic [SelW-1:0]  sel;
      logic             conf;
      logic             sticky;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic clr = 1'b1;

   logic [WORD-1:0]       src_words [N_SRC];
   logic [N_SRC*WORD-1:0] src_flat;
   logic [N_SRC-1:0]      src_en   = '0;
   logic                  c_en     = 1'b0;
   logic [C_WIDTH-1:0]    c_field  = '0;
   logic                  err_clr  = 1'b0;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb_q[$];

   // Model state
   logic [WORD-1:0]  m_bus    = '0;
   logic             m_sticky = 1'b0;
   logic [CNT_W-1:0] m_cnt    = '0;

   always #5 clk = ~clk;

   always_comb begin
      src_flat = '0;
      for (int i = 0; i < N_SRC; i++) src_flat[i*WORD +: WORD] = src_words[i];
   end

   bus_mux_reg_if #(.WORD(WORD), .N_SRC(N_SRC), .C_WIDTH(C_WIDTH), .CNT_W(CNT_W)) if_h ();
   bus_mux_reg_if #(.WORD(WORD), .N_SRC(N_SRC), .C_WIDTH(C_WIDTH), .CNT_W(CNT_W)) if_z ();

   assign if_h.src_en   = src_en;
   assign if_h.src_data = src_flat;
   assign if_h.c_en     = c_en;
   assign if_h.c_field  = c_field;
   assign if_h.err_clr  = err_clr;
   assign if_z.src_en   = src_en;
   assign if_z.src_data = src_flat;
   assign if_z.c_en     = c_en;
   assign if_z.c_field  = c_field;
   assign if_z.err_clr  = err_clr;

   bus_mux_reg #(
      .WORD(WORD), .N_SRC(N_SRC), .C_WIDTH(C_WIDTH), .HOLD_IDLE(1'b1), .CNT_W(CNT_W)
   ) u_dut_hold (
      .clk    (clk),
      .clr    (clr),
      .bus_if (if_h)
   );

   bus_mux_reg #(
      .WORD(WORD), .N_SRC(N_SRC), .C_WIDTH(C_WIDTH), .HOLD_IDLE(1'b0), .CNT_W(CNT_W)
   ) u_dut_zero (
      .clk    (clk),
      .clr    (clr),
      .bus_if (if_z)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Apply one cycle of stimulus, queue the model's prediction, compare after the edge.
   task automatic drive(input logic [N_SRC-1:0] en, input logic ce,
                        input logic [C_WIDTH-1:0] cf, input logic ec);
      exp_t e;
      logic [N_SRC:0] d;
      logic signed [WORD-1:0] cval;
      int w;
      int n;
      src_en  = en;
      c_en    = ce;
      c_field = cf;
      err_clr = ec;

      d    = {ce, en};
      n    = $countones(d);
      cval = $signed(cf);
      w    = -1;
      for (int i = 0; i <= N_SRC; i++) begin
         if (w < 0 && d[i]) w = i;
      end

      if (w < 0) begin
         e.valid    = 1'b0;
         e.sel      = '0;
         e.bus_zero = '0;
      end else begin
         e.valid = 1'b1;
         e.sel   = SelW'(w);
         m_bus   = (w == N_SRC) ? cval : src_words[w];
         e.bus_zero = m_bus;
      end
      e.bus_hold = m_bus;

      if (ec) begin
         m_sticky = 1'b0;
         m_cnt    = '0;
      end
      if (n >= 2) begin
         m_sticky = 1'b1;
         if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1;
      end
      e.conf   = (n >= 2);
      e.sticky = m_sticky;
      e.cnt    = m_cnt;
      sb_q.push_back(e);

      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check("bus_hold", if_h.bus_out, e.bus_hold);
      check("bus_zero", if_z.bus_out, e.bus_zero);
      check("valid",    if_h.bus_valid, e.valid);
      check("sel",      if_h.sel_idx, e.sel);
      check("conflict", if_h.conflict, e.conf);
      check("sticky",   if_h.conflict_sticky, e.sticky);
      check("cnt",      if_h.conflict_cnt, e.cnt);
      check("cnt_zero", if_z.conflict_cnt, e.cnt);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_bus"},    if_h.bus_out, '0);
      check({tag, "_busz"},   if_z.bus_out, '0);
      check({tag, "_valid"},  if_h.bus_valid, '0);
      check({tag, "_sel"},    if_h.sel_idx, '0);
      check({tag, "_conf"},   if_h.conflict, '0);
      check({tag, "_sticky"}, if_h.conflict_sticky, '0);
      check({tag, "_cnt"},    if_h.conflict_cnt, '0);
   endtask

   initial begin
      logic [N_SRC-1:0] en;
      for (int i = 0; i < N_SRC; i++) src_words[i] = $urandom;
      src_words[2] = 32'h2222_0002;
      src_words[3] = 32'h3333_0003;
      src_words[5] = 32'hDEAD_BEEF;
      src_words[9] = 32'h9999_0009;

      // Reset state
      #1;
      check_zero("rst");
      #11;
      clr = 1'b0;
      @(posedge clk);
      #1;

      // Latency and select
      drive(N_SRC'(1) << 5, 1'b0, '0, 1'b0);

      // C sign extension
      drive('0, 1'b1, 19'h7FFFF, 1'b0);
      drive('0, 1'b1, 19'h3FFFF, 1'b0);

      // Idle hold versus zero-load
      src_words[1] = 32'h0000_1234;
      drive(N_SRC'(1) << 1, 1'b0, '0, 1'b0);
      repeat (3) drive('0, 1'b0, '0, 1'b0);

      // Three-way conflict; R2 wins
      en = (N_SRC'(1) << 2) | (N_SRC'(1) << 9);
      drive(en, 1'b1, 19'h12345, 1'b0);
      drive('0, 1'b0, '0, 1'b0);
      drive(N_SRC'(1) << 9, 1'b0, '0, 1'b0);

      // err_clr concurrent with a conflict, then alone on an idle bus
      drive(en, 1'b0, '0, 1'b0);
      drive(en, 1'b1, 19'h00001, 1'b1);
      drive('0, 1'b0, '0, 1'b1);

      // Saturation of the conflict counter
      repeat (300) drive(en, 1'b1, '0, 1'b0);
      drive(N_SRC'(1) << 4, 1'b0, '0, 1'b0);

      // Asynchronous reset mid-stream with R3 driving
      src_en = N_SRC'(1) << 3;
      #1;
      clr = 1'b1;
      #1;
      check_zero("mid_rst");
      #1;
      clr      = 1'b0;
      m_bus    = '0;
      m_sticky = 1'b0;
      m_cnt    = '0;
      drive(N_SRC'(1) << 3, 1'b0, '0, 1'b0);
      drive('0, 1'b0, '0, 1'b0);

      // Random mix of one-hot, multi-driver, C-only and idle cycles
      for (int k = 0; k < 40; k++) begin
         case ($urandom_range(0, 3))
            0: en = N_SRC'(1) << $urandom_range(0, N_SRC - 1);
            1: en = N_SRC'($urandom);
            default: en = '0;
         endcase
         drive(en, 1'($urandom), C_WIDTH'($urandom), ($urandom_range(0, 7) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
